// File: rtl/equiv_mismatch_monitor.sv
// Equivalence monitor for two design instances: skips a warm-up window, then flags y_1/y_2
// divergence, latches the first failure and counts mismatches. Optional assertion: EQUIV_MON_ASSERT_EN.
module equiv_mismatch_monitor #(
  parameter int WIDTH  = 91,
  parameter int WARMUP = 4,
  parameter int CYC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] y_1,
  input  logic [WIDTH-1:0] y_2,
  output logic             mismatch,
  output logic             failed,
  output logic             checking,
  output logic [CYC_W-1:0] first_fail_cycle,
  output logic [WIDTH-1:0] first_fail_diff,
  output logic [CNT_W-1:0] fail_count
);

  // state  | meaning
  // WARM   | counting en-qualified samples of the warm-up window, no compare
  // CHECK  | comparing every en-qualified sample, no mismatch seen yet
  // FAILED | at least one mismatch seen; keeps counting until rst/clear
  typedef enum logic [1:0] {WARM, CHECK, FAILED} state_t;

  localparam int     WC_W      = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam state_t RST_STATE = (WARMUP == 0) ? CHECK : WARM;
  localparam logic [WC_W-1:0] WARM_LAST = WC_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  state_t            state, state_nxt;
  logic [WC_W-1:0]   warm_cnt;
  logic [CYC_W-1:0]  sample_idx;
  logic              chk;
  logic              hit;
  logic              take_first;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    chk        = en && !clear && (state != WARM);
    // case inequality so X/Z on either side counts as divergence in simulation
    hit        = chk && (y_1 !== y_2);
    take_first = hit && (state == CHECK);
    if (clear) begin
      state_nxt = RST_STATE;
    end else if (en) begin
      case (state)
        WARM:    if (warm_cnt == WARM_LAST) state_nxt = CHECK;
        CHECK:   if (hit) state_nxt = FAILED;
        FAILED:  state_nxt = FAILED;
        default: state_nxt = RST_STATE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt         <= '0;
      sample_idx       <= '0;
      mismatch         <= 1'b0;
      failed           <= 1'b0;
      first_fail_cycle <= '0;
      first_fail_diff  <= '0;
      fail_count       <= '0;
    end else if (clear) begin
      warm_cnt         <= '0;
      sample_idx       <= '0;
      mismatch         <= 1'b0;
      failed           <= 1'b0;
      first_fail_cycle <= '0;
      first_fail_diff  <= '0;
      fail_count       <= '0;
    end else begin
      mismatch <= hit;
      if (en) begin
        if (sample_idx != '1) sample_idx <= sample_idx + CYC_W'(1);
        if (state == WARM) warm_cnt <= warm_cnt + WC_W'(1);
      end
      if (hit) begin
        failed <= 1'b1;
        if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
      end
      if (take_first) begin
        first_fail_cycle <= sample_idx;
        first_fail_diff  <= y_1 ^ y_2;
      end
    end
  end

  assign checking = (state != WARM);

`ifdef EQUIV_MON_ASSERT_EN
  always @(posedge clk) begin
    if (!rst && chk)
      assert (y_1 === y_2)
      else $error("equiv mismatch at sample %0d diff %h", sample_idx, y_1 ^ y_2);
  end
`endif

endmodule

// File: tb/tb_equiv_mismatch_monitor.sv
// Scoreboard bench for equiv_mismatch_monitor: a behavioural model queues expected outputs
// per driven cycle; a second instance with CNT_W=2 exercises fail_count saturation.
module tb_equiv_mismatch_monitor;
  localparam int W = 91;

  logic         clk = 1'b0;
  logic         rst, en, clear;
  logic [W-1:0] y_1, y_2;

  logic         mismatch, failed, checking;
  logic [31:0]  first_fail_cycle;
  logic [W-1:0] first_fail_diff;
  logic [15:0]  fail_count;

  logic         mismatch2, failed2, checking2;
  logic [31:0]  first_fail_cycle2;
  logic [W-1:0] first_fail_diff2;
  logic [1:0]   fail_count2;

  always #5 clk = ~clk;

  equiv_mismatch_monitor u_dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .y_1(y_1), .y_2(y_2),
    .mismatch(mismatch), .failed(failed), .checking(checking),
    .first_fail_cycle(first_fail_cycle), .first_fail_diff(first_fail_diff),
    .fail_count(fail_count)
  );

  equiv_mismatch_monitor #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .y_1(y_1), .y_2(y_2),
    .mismatch(mismatch2), .failed(failed2), .checking(checking2),
    .first_fail_cycle(first_fail_cycle2), .first_fail_diff(first_fail_diff2),
    .fail_count(fail_count2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic         mis;
    logic         failed;
    logic         checking;
    logic [31:0]  ffc;
    logic [W-1:0] ffd;
    logic [15:0]  cnt;
    logic [1:0]   cnt2;
  } exp_t;

  exp_t sb[$];

  // reference model
  int           m_state;  // 0 warm-up, 1 checking, 2 failed
  int           m_wcnt;
  logic [31:0]  m_idx;
  logic         m_mis, m_failed;
  logic [31:0]  m_ffc;
  logic [W-1:0] m_ffd;
  int           m_cnt, m_cnt2;

  function automatic void model_reset();
    m_state = 0; m_wcnt = 0; m_idx = 0; m_mis = 0; m_failed = 0;
    m_ffc = 0; m_ffd = '0; m_cnt = 0; m_cnt2 = 0;
  endfunction

  function automatic void model_step(input logic e, input logic c,
                                     input logic [W-1:0] a, input logic [W-1:0] b);
    logic bad;
    if (c) begin
      model_reset();
      return;
    end
    if (!e) begin
      m_mis = 0;
      return;
    end
    bad   = (m_state != 0) && (a !== b);
    m_mis = bad;
    if (bad) begin
      if (m_state == 1) begin
        m_ffc = m_idx;
        m_ffd = a ^ b;
        m_state = 2;
      end
      m_failed = 1;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (m_state == 0) begin
      if (m_wcnt == 3) m_state = 1;
      m_wcnt++;
    end
    if (m_idx != 32'hFFFF_FFFF) m_idx++;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.mis = m_mis; e.failed = m_failed; e.checking = (m_state != 0);
    e.ffc = m_ffc; e.ffd = m_ffd; e.cnt = 16'(m_cnt); e.cnt2 = 2'(m_cnt2);
    sb.push_back(e);
  endfunction

  task automatic compare_head(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".mismatch"}, 128'(mismatch), 128'(e.mis));
    chk({tag, ".failed"}, 128'(failed), 128'(e.failed));
    chk({tag, ".checking"}, 128'(checking), 128'(e.checking));
    chk({tag, ".ffc"}, 128'(first_fail_cycle), 128'(e.ffc));
    chk({tag, ".ffd"}, 128'(first_fail_diff), 128'(e.ffd));
    chk({tag, ".cnt"}, 128'(fail_count), 128'(e.cnt));
    chk({tag, ".cnt2"}, 128'(fail_count2), 128'(e.cnt2));
    chk({tag, ".failed2"}, 128'(failed2), 128'(e.failed));
  endtask

  task automatic step(input string tag, input logic e, input logic c,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    en = e; clear = c; y_1 = a; y_2 = b;
    model_step(e, c, a, b);
    push_exp();
    @(posedge clk);
    #1;
    compare_head(tag);
  endtask

  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom(), $urandom()});
  endfunction

  logic [W-1:0] v;

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; y_1 = '0; y_2 = '0;
    model_reset();
    #12;
    push_exp();
    compare_head("reset");
    @(negedge clk);
    rst = 1'b0;

    // warm-up: a mismatch on sample 3 is ignored
    for (int i = 0; i < 3; i++) step("warm_eq", 1, 0, '0, '0);
    step("warm_last_diff", 1, 0, W'(1), '0);

    // first failure at sample 6
    for (int i = 0; i < 2; i++) begin
      v = rnd();
      step("check_eq", 1, 0, v, v);
    end
    step("first_fail", 1, 0, W'(1), '0);
    step("second_fail", 1, 0, W'(4), '0);
    v = rnd();
    step("after_fail_eq", 1, 0, v, v);
    step("idle", 0, 0, W'(7), '0);

    // saturation of the CNT_W=2 instance
    step("clear", 0, 1, '0, '0);
    for (int i = 0; i < 4; i++) step("rewarm", 1, 0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      v = rnd();
      step("sat_fail", 1, 0, v, v ^ (W'(1) << i));
    end
    step("sat_eq", 1, 0, '0, '0);

    // clear wins over a simultaneous mismatch
    step("clear_vs_mis", 1, 1, W'(5), '0);

    // en toggling during warm-up; mismatches only on en=0 cycles
    for (int i = 0; i < 4; i++) begin
      step("tog_en1", 1, 0, W'(9), W'(9));
      step("tog_en0", 0, 0, W'(1), '0);
    end
    step("chk_en0_diff", 0, 0, W'(3), '0);
    step("chk_eq", 1, 0, W'(2), W'(2));
    step("idx_fail", 1, 0, W'(2), '0);

    // asynchronous reset mid-FAILED, checked before the next clock edge
    @(negedge clk);
    en = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    push_exp();
    compare_head("async_rst");
    #1 rst = 1'b0;

    // random traffic
    for (int i = 0; i < 80; i++) begin
      logic e, c;
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      v = rnd();
      if ($urandom_range(0, 2) == 0) step("rand", e, c, v, v ^ (W'(1) << $urandom_range(0, W-1)));
      else                           step("rand", e, c, v, v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
